uart_transmitter: RTL and testbench

//  Serialises 8-bit parallel words onto a UART line as 8N1 frames. It is the

---
 rtl/uart_transmitter_if.sv | 18 +
 rtl/uart_transmitter.sv | 140 ++++++++++++++
 tb/tb_uart_transmitter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - producer-to-transmitter byte handshake
//
// Purpose: groups the valid/ready word handshake between a byte producer
//          (master) and the UART transmitter (slave).
// Signals:
//   tx_data   word offered by the producer
//   tx_valid  producer has a word on tx_data
//   tx_ready  transmitter holding register is empty
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1-style UART serialiser with one-word holding register
//
// Purpose: takes words over a valid/ready handshake and shifts them out as
//          start / DATA_BITS data / STOP_BITS stop frames. A holding register
//          lets the next word queue up so consecutive frames have no idle gap.
// Ports:
//   clk         system clock, posedge
//   reset       asynchronous, active-low reset
//   tx          slave side of the word handshake (tx_data/tx_valid/tx_ready)
//   serial_out  UART line, idle high, driven straight from a flop
//   t_busy      high while a frame is in progress
module uart_transmitter #(
  parameter int CYCLES_PER_BIT = 868,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int MSB_FIRST      = 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_transmitter_if.slave   tx,
  output logic                serial_out,
  output logic                t_busy
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cyc_cnt, cyc_d;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shifter, shifter_d;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full, hold_full_d;
  logic                 line_d;
  logic                 load;
  logic                 accept;
  logic                 bit_end;

  assign tx.tx_ready = !hold_full;
  assign accept      = tx.tx_valid && !hold_full;
  assign bit_end     = (cyc_cnt == CW'(CYCLES_PER_BIT - 1));
  assign t_busy      = (state != IDLE);

  // line_d is the level for the current state; it is registered into
  // serial_out, so the line trails the state by one cycle uniformly and
  // every bit period (start, data, stop) stays exactly CYCLES_PER_BIT long.
  always_comb begin
    state_d   = state;
    cyc_d     = cyc_cnt;
    bit_d     = bit_cnt;
    shifter_d = shifter;
    load      = 1'b0;
    line_d    = 1'b1;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_d = START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        line_d = 1'b0;
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        line_d = (MSB_FIRST != 0) ? shifter[DATA_BITS-1] : shifter[0];
        if (bit_end) begin
          cyc_d     = '0;
          shifter_d = (MSB_FIRST != 0) ? {shifter[DATA_BITS-2:0], 1'b0}
                                       : {1'b0, shifter[DATA_BITS-1:1]};
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          cyc_d = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            // A queued word starts its frame right after the last stop bit.
            if (hold_full) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          cyc_d = cyc_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shifter_d = hold_reg;
    end
    hold_full_d = (hold_full && !load) || accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_d;
      cyc_cnt    <= cyc_d;
      bit_cnt    <= bit_d;
      shifter    <= shifter_d;
      hold_full  <= hold_full_d;
      serial_out <= line_d;
      if (accept) begin
        hold_reg <= tx.tx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_transmitter_if #(.DATA_BITS(8)) bus_a ();
  uart_transmitter_if #(.DATA_BITS(8)) bus_b ();
  logic line_a, busy_a, line_b, busy_b;

  uart_transmitter #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .tx(bus_a), .serial_out(line_a), .t_busy(busy_a));
  uart_transmitter #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .tx(bus_b), .serial_out(line_b), .t_busy(busy_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for sample idx of a frame: start, data bits, then stop.
  function automatic bit frame_bit(input logic [7:0] d, input int idx, input bit msb_first);
    int slot;
    slot = idx / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return msb_first ? d[8-slot] : d[slot-1];
    return 1'b1;
  endfunction

  // Model: a queue of future line levels, one per clock. A held word becomes a
  // frame as soon as the queue has drained, so frames abut with no gap.
  bit         qa[$];
  bit         qb[$];
  bit         ha_full = 1'b0;
  bit         hb_full = 1'b0;
  logic [7:0] ha, hb;
  bit         ea_line = 1'b1;
  bit         eb_line = 1'b1;

  always @(posedge clk or negedge reset) begin : model_a
    bit acc;
    if (!reset) begin
      qa.delete();
      ha_full = 1'b0;
      ea_line = 1'b1;
    end else begin
      acc = bus_a.tx_valid && !ha_full;
      ea_line = (qa.size() > 0) ? qa.pop_front() : 1'b1;
      if (ha_full && qa.size() == 0) begin
        for (int i = 0; i < 10 * CPB; i++) qa.push_back(frame_bit(ha, i, 1'b1));
        ha_full = 1'b0;
      end
      if (acc) begin
        ha = bus_a.tx_data;
        ha_full = 1'b1;
      end
    end
  end

  always @(posedge clk or negedge reset) begin : model_b
    bit acc;
    if (!reset) begin
      qb.delete();
      hb_full = 1'b0;
      eb_line = 1'b1;
    end else begin
      acc = bus_b.tx_valid && !hb_full;
      eb_line = (qb.size() > 0) ? qb.pop_front() : 1'b1;
      if (hb_full && qb.size() == 0) begin
        for (int i = 0; i < 11 * CPB; i++) qb.push_back(frame_bit(hb, i, 1'b0));
        hb_full = 1'b0;
      end
      if (acc) begin
        hb = bus_b.tx_data;
        hb_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk1("a_line", line_a, ea_line);
    chk1("a_ready", bus_a.tx_ready, !ha_full);
    chk1("a_busy", busy_a, qa.size() != 0);
    chk1("b_line", line_b, eb_line);
    chk1("b_ready", bus_b.tx_ready, !hb_full);
    chk1("b_busy", busy_b, qb.size() != 0);
  end

  // Loopback receiver on line_a (MSB first, mid-bit sampling).
  int         rx_cnt = -1;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (!line_a) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh = {rx_sh[6:0], line_a};
        if (rx_cnt / CPB == 9) begin
          rx_q.push_back(rx_sh);
          rx_cnt = -1;
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] d);
    int t;
    @(negedge clk);
    if (sel) begin bus_b.tx_valid = 1'b1; bus_b.tx_data = d; end
    else     begin bus_a.tx_valid = 1'b1; bus_a.tx_data = d; end
    for (t = 0; t < 1000; t++) begin
      if (sel ? bus_b.tx_ready : bus_a.tx_ready) break;
      @(negedge clk);
    end
    if (t >= 1000) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: tx_ready never rose, required 1");
    end
    @(posedge clk);
    @(negedge clk);
    if (sel) begin bus_b.tx_valid = 1'b0; bus_b.tx_data = ~d; end
    else     begin bus_a.tx_valid = 1'b0; bus_a.tx_data = ~d; end
  endtask

  task automatic wait_idle();
    int t;
    repeat (2) @(negedge clk);
    for (t = 0; t < 2000; t++) begin
      if (!busy_a && !busy_b) break;
      @(negedge clk);
    end
    chkn("idle_timeout", t, (t < 2000) ? t : -1);
  endtask

  bit exp2[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit exp6[8] = '{1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int cnt;
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data  = 8'h55;
    bus_b.tx_valid = 1'b0;
    bus_b.tx_data  = 8'h00;

    // 1: reset held with valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("t1_line", line_a, 1'b1);
    chk1("t1_ready", bus_a.tx_ready, 1'b1);
    chk1("t1_busy", busy_a, 1'b0);
    bus_a.tx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk1("t1_idle_line", line_a, 1'b1);
    chk1("t1_idle_busy", busy_a, 1'b0);

    // 2: single frame 8'hA5, MSB first
    rx_q.delete();
    send(1'b0, 8'hA5);
    chk1("t2_n0_line", line_a, 1'b1);
    @(negedge clk);
    chk1("t2_n1_line", line_a, 1'b1);
    chk1("t2_n1_busy", busy_a, 1'b1);
    @(negedge clk);
    chk1("t2_start", line_a, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      chk1("t2_bit", line_a, exp2[k]);
    end
    repeat (CPB) @(negedge clk);
    chk1("t2_stop", line_a, 1'b1);
    chk1("t2_stop_busy", busy_a, 1'b1);
    repeat (6) @(negedge clk);
    chk1("t2_busy_last", busy_a, 1'b1);
    @(negedge clk);
    chk1("t2_busy_off", busy_a, 1'b0);
    chkn("t2_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chkn("t2_rx_byte", int'(rx_q[0]), 'hA5);

    // 3: back-to-back 8'h00 then 8'hFF
    rx_q.delete();
    cnt = 0;
    fork
      begin
        send(1'b0, 8'h00);
        repeat (20) @(negedge clk);
        send(1'b0, 8'hFF);
      end
      begin
        for (int t = 0; t < 600; t++) begin
          @(negedge clk);
          if (busy_a) cnt++;
          else if (cnt > 0) break;
        end
      end
    join
    chkn("t3_busy_span", cnt, 160);
    chkn("t3_rx_count", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      chkn("t3_rx0", int'(rx_q[0]), 'h00);
      chkn("t3_rx1", int'(rx_q[1]), 'hFF);
    end

    // 4: three words offered rapidly, third waits on a full holding register
    rx_q.delete();
    send(1'b0, 8'h5A);
    send(1'b0, 8'hC3);
    chk1("t4_full_ready", bus_a.tx_ready, 1'b0);
    send(1'b0, 8'h7E);
    wait_idle();
    chkn("t4_rx_count", rx_q.size(), 3);
    if (rx_q.size() > 2) begin
      chkn("t4_rx0", int'(rx_q[0]), 'h5A);
      chkn("t4_rx1", int'(rx_q[1]), 'hC3);
      chkn("t4_rx2", int'(rx_q[2]), 'h7E);
    end

    // 5: reset in the middle of 8'h3C, then 8'h81
    rx_q.delete();
    send(1'b0, 8'h3C);
    repeat (45) @(negedge clk);
    chk1("t5_busy_before", busy_a, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("t5_line_async", line_a, 1'b1);
    chk1("t5_ready_async", bus_a.tx_ready, 1'b1);
    chk1("t5_busy_async", busy_a, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(1'b0, 8'h81);
    wait_idle();
    chkn("t5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chkn("t5_rx_byte", int'(rx_q[0]), 'h81);

    // 6: LSB first, two stop bits, 8'h01
    send(1'b1, 8'h01);
    chk1("t6_n0_line", line_b, 1'b1);
    @(negedge clk);
    chk1("t6_n1_busy", busy_b, 1'b1);
    @(negedge clk);
    chk1("t6_start", line_b, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      chk1("t6_bit", line_b, exp6[k]);
    end
    repeat (CPB) @(negedge clk);
    chk1("t6_stop1", line_b, 1'b1);
    repeat (CPB) @(negedge clk);
    chk1("t6_stop2", line_b, 1'b1);
    chk1("t6_stop2_busy", busy_b, 1'b1);
    repeat (6) @(negedge clk);
    chk1("t6_busy_last", busy_b, 1'b1);
    @(negedge clk);
    chk1("t6_busy_off", busy_b, 1'b0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
